poly_audio_synth_codec: RTL and testbench

- Parametrised successor to the fixed 4-voice codec driver.
- Generates NUM_VOICES independent DDS voices, each with a runtime frequency word and gate.
- Waveform is runtime-selectable: sine, square, saw or triangle.
- Voices are mixed sequentially with saturation, and the result is serialised to the audio DAC as left-justified, MSB-first, 48 kHz stereo (same sample on both channels) from the 18.432 MHz clock.

---
 rtl/synth_pkg.sv | 23 ++
 rtl/synth_sine_lut.sv | 25 ++
 rtl/poly_audio_synth_codec.sv | 196 +++++++++++++++++++
 tb/tb_poly_audio_synth_codec.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/synth_pkg.sv
// Shared definitions for the polyphonic synth codec: waveform codes, mix FSM
// states, clock constants and a clog2 helper.
package synth_pkg;

    localparam logic [1:0] WAVE_SINE   = 2'b00;
    localparam logic [1:0] WAVE_SQUARE = 2'b01;
    localparam logic [1:0] WAVE_SAW    = 2'b10;
    localparam logic [1:0] WAVE_TRI    = 2'b11;

    typedef enum logic [1:0] {MIX_IDLE, MIX_ACC, MIX_SAT, MIX_DONE} mix_state_t;

    localparam int REF_CLK     = 18432000;
    localparam int SAMPLE_RATE = 48000;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++)
            if ((1 << i) < n) r = i + 1;
        return r;
    endfunction

endpackage

// File: rtl/synth_sine_lut.sv
// Combinational sine ROM: one full period over 2^LUT_ADDR_WIDTH entries,
// rounded to nearest, peak 2^(DATA_WIDTH-1)-1. Built at elaboration time.
module synth_sine_lut
    import synth_pkg::*;
#(
    parameter int LUT_ADDR_WIDTH = 6,
    parameter int DATA_WIDTH     = 16
) (
    input  logic [LUT_ADDR_WIDTH-1:0]   addr,
    output logic signed [DATA_WIDTH-1:0] data
);
    localparam int  DEPTH = 1 << LUT_ADDR_WIDTH;
    localparam real PI    = 3.14159265358979323846;
    localparam real FSR   = 1.0 * ((1 << (DATA_WIDTH - 1)) - 1);

    logic signed [DATA_WIDTH-1:0] rom [DEPTH];

    for (genvar i = 0; i < DEPTH; i++) begin : g_rom
        localparam real S = FSR * $sin(2.0 * PI * i / DEPTH);
        assign rom[i] = DATA_WIDTH'($rtoi(S >= 0.0 ? S + 0.5 : S - 0.5));
    end

    assign data = rom[addr];

endmodule

// File: rtl/poly_audio_synth_codec.sv
// NUM_VOICES-voice DDS synth, sequential saturating mixer and left-justified
// stereo DAC serialiser. Define SOFT_GATE_EN for per-voice attack/release ramps.
module poly_audio_synth_codec
    import synth_pkg::*;
#(
    parameter int NUM_VOICES     = 4,
    parameter int DATA_WIDTH     = 16,
    parameter int PHASE_WIDTH    = 16,
    parameter int LUT_ADDR_WIDTH = 6,
    parameter int BCK_HALF_DIV   = 6
) (
    input  logic                              iCLK_18_4,
    input  logic                              iRST,
    input  logic [NUM_VOICES-1:0]             iKEY_ON,
    input  logic [NUM_VOICES*PHASE_WIDTH-1:0] iPHASE_INC,
    input  logic [1:0]                        iWAVE_SEL,
    output logic                              oAUD_BCK,
    output logic                              oAUD_LRCK,
    output logic                              oAUD_DATA,
    output logic                              oSAMPLE_STB,
    output logic                              oCLIP
);
    localparam int DW = DATA_WIDTH;
    localparam int AW = DW + clog2(NUM_VOICES) + 1;
    localparam int VW = (clog2(NUM_VOICES) > 0) ? clog2(NUM_VOICES) : 1;
    localparam int CW = (clog2(BCK_HALF_DIV) > 0) ? clog2(BCK_HALF_DIV) : 1;
    localparam int BW = (clog2(DW) > 0) ? clog2(DW) : 1;
    localparam logic signed [DW-1:0] FS = {1'b0, {(DW-1){1'b1}}};

    logic [CW-1:0]        bck_cnt;
    logic [BW-1:0]        bit_cnt;
    logic [DW-1:0]        shifter, dac_word, hold;
    logic                 bck_fall, frame_edge;

    assign bck_fall   = (bck_cnt == CW'(BCK_HALF_DIV - 1)) && oAUD_BCK;
    assign frame_edge = bck_fall && (bit_cnt == BW'(DW - 1));
    assign oAUD_DATA  = shifter[DW-1];

    // dac_word keeps the left sample so the right half repeats it even if the
    // mixer has already refreshed hold mid-frame.
    always_ff @(posedge iCLK_18_4) begin
        if (iRST) begin
            bck_cnt     <= '0;
            bit_cnt     <= '0;
            oAUD_BCK    <= 1'b0;
            oAUD_LRCK   <= 1'b0;
            oSAMPLE_STB <= 1'b0;
            shifter     <= '0;
            dac_word    <= '0;
        end else begin
            oSAMPLE_STB <= 1'b0;
            if (bck_cnt == CW'(BCK_HALF_DIV - 1)) begin
                bck_cnt  <= '0;
                oAUD_BCK <= ~oAUD_BCK;
            end else begin
                bck_cnt <= bck_cnt + 1'b1;
            end
            if (bck_fall) begin
                bit_cnt <= frame_edge ? '0 : bit_cnt + 1'b1;
                if (frame_edge) begin
                    oAUD_LRCK <= ~oAUD_LRCK;
                    if (oAUD_LRCK) begin
                        shifter     <= hold;
                        dac_word    <= hold;
                        oSAMPLE_STB <= 1'b1;
                    end else begin
                        shifter <= dac_word;
                    end
                end else begin
                    shifter <= {shifter[DW-2:0], 1'b0};
                end
            end
        end
    end

    mix_state_t                             state, state_nxt;
    logic [VW-1:0]                          vidx;
    logic signed [AW-1:0]                   acc;
    logic signed [DW-1:0]                   sat_val;
    logic [NUM_VOICES-1:0][PHASE_WIDTH-1:0] phase;
    logic [PHASE_WIDTH-1:0]                 ph_cur, inc_cur;
    logic [DW-1:0]                          p, saw_raw, tri_fold, tri_raw;
    logic signed [DW-1:0]                   sine_val, wave, contrib;
    logic                                   voice_live;

    assign ph_cur  = phase[vidx];
    assign inc_cur = iPHASE_INC[vidx*PHASE_WIDTH +: PHASE_WIDTH];

    if (PHASE_WIDTH >= DW) begin : g_p_trunc
        assign p = ph_cur[PHASE_WIDTH-1 -: DW];
    end else begin : g_p_pad
        assign p = {ph_cur, {(DW-PHASE_WIDTH){1'b0}}};
    end

    synth_sine_lut #(.LUT_ADDR_WIDTH(LUT_ADDR_WIDTH), .DATA_WIDTH(DW)) u_sine (
        .addr (p[DW-1 -: LUT_ADDR_WIDTH]),
        .data (sine_val)
    );

    assign saw_raw  = {~p[DW-1], p[DW-2:0]};
    assign tri_fold = p[DW-1] ? {~p[DW-2:0], 1'b0} : {p[DW-2:0], 1'b0};
    assign tri_raw  = {~tri_fold[DW-1], tri_fold[DW-2:0]};

    // The only code below -FS is the most negative one; pin it to -FS so
    // every waveform is symmetric.
    function automatic logic signed [DW-1:0] floor_fs(input logic [DW-1:0] x);
        return (signed'(x) < -FS) ? -FS : signed'(x);
    endfunction

    always_comb begin
        wave = '0;
        case (iWAVE_SEL)
            WAVE_SINE:   wave = sine_val;
            WAVE_SQUARE: wave = ph_cur[PHASE_WIDTH-1] ? -FS : FS;
            WAVE_SAW:    wave = floor_fs(saw_raw);
            default:     wave = floor_fs(tri_raw);
        endcase
    end

`ifdef SOFT_GATE_EN
    logic [NUM_VOICES-1:0][3:0] gain;
    logic [3:0]                 g_cur;
    logic signed [DW+4:0]       scaled;

    assign g_cur      = gain[vidx];
    assign scaled     = ((DW+5)'(wave) * (DW+5)'($signed({1'b0, g_cur}))) >>> 4;
    assign contrib    = DW'(scaled);
    assign voice_live = iKEY_ON[vidx] || (g_cur != 4'd0);

    always_ff @(posedge iCLK_18_4) begin
        if (iRST)
            gain <= '0;
        else if (state == MIX_ACC)
            gain[vidx] <= iKEY_ON[vidx] ? ((g_cur == 4'd15) ? g_cur : g_cur + 4'd1)
                                        : ((g_cur == 4'd0)  ? g_cur : g_cur - 4'd1);
    end
`else
    assign contrib    = wave;
    assign voice_live = iKEY_ON[vidx];
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            MIX_IDLE: if (oSAMPLE_STB) state_nxt = MIX_ACC;
            MIX_ACC:  if (vidx == VW'(NUM_VOICES - 1)) state_nxt = MIX_SAT;
            MIX_SAT:  state_nxt = MIX_DONE;
            MIX_DONE: state_nxt = MIX_IDLE;
            default:  state_nxt = MIX_IDLE;
        endcase
    end

    always_ff @(posedge iCLK_18_4) begin
        if (iRST) begin
            state   <= MIX_IDLE;
            vidx    <= '0;
            acc     <= '0;
            phase   <= '0;
            sat_val <= '0;
            hold    <= '0;
            oCLIP   <= 1'b0;
        end else begin
            state <= state_nxt;
            oCLIP <= 1'b0;
            case (state)
                MIX_IDLE: begin
                    acc  <= '0;
                    vidx <= '0;
                end
                MIX_ACC: begin
                    vidx <= vidx + 1'b1;
                    if (voice_live) begin
                        acc         <= acc + AW'(contrib);
                        phase[vidx] <= ph_cur + inc_cur;
                    end else begin
                        phase[vidx] <= '0;
                    end
                end
                MIX_SAT: begin
                    if (acc > AW'(FS)) begin
                        sat_val <= FS;
                        oCLIP   <= 1'b1;
                    end else if (acc < -AW'(FS)) begin
                        sat_val <= -FS;
                        oCLIP   <= 1'b1;
                    end else begin
                        sat_val <= DW'(acc);
                    end
                end
                MIX_DONE: hold <= sat_val;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_poly_audio_synth_codec.sv
// Randomised self-checking bench: deserialises the DAC stream and compares each
// channel word against a frame-level arithmetic model of the voices and mixer.
module tb_poly_audio_synth_codec;
    localparam int NV = 4;
    localparam int DW = 16;
    localparam int PW = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic [NV-1:0]     key_on;
    logic [NV*PW-1:0]  phase_inc;
    logic [1:0]        wave_sel;
    logic              aud_bck, aud_lrck, aud_data, sample_stb, clip;

    always #27 clk = ~clk;

    poly_audio_synth_codec #(.NUM_VOICES(NV), .DATA_WIDTH(DW), .PHASE_WIDTH(PW),
                             .LUT_ADDR_WIDTH(6), .BCK_HALF_DIV(6)) dut (
        .iCLK_18_4   (clk),
        .iRST        (rst),
        .iKEY_ON     (key_on),
        .iPHASE_INC  (phase_inc),
        .iWAVE_SEL   (wave_sel),
        .oAUD_BCK    (aud_bck),
        .oAUD_LRCK   (aud_lrck),
        .oAUD_DATA   (aud_data),
        .oSAMPLE_STB (sample_stb),
        .oCLIP       (clip)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int m_phase [NV];
    int m_gain  [NV];
    int exp_q [$];
    int m_clips, dut_clips;

    function automatic int wave_of(input int ph, input logic [1:0] sel);
        int  w;
        real s;
        case (sel)
            2'b00: begin
                s = 32767.0 * $sin(2.0 * 3.14159265358979323846 * (ph >> 10) / 64.0);
                w = $rtoi(s >= 0.0 ? s + 0.5 : s - 0.5);
            end
            2'b01:   w = (ph < 32768) ? 32767 : -32767;
            2'b10:   w = ph - 32768;
            default: w = ((ph < 32768) ? 2 * ph : 2 * (65535 - ph)) - 32768;
        endcase
        if (w < -32767) w = -32767;
        return w;
    endfunction

    task automatic model_reset();
        for (int v = 0; v < NV; v++) begin
            m_phase[v] = 0;
            m_gain[v]  = 0;
        end
        exp_q.delete();
        exp_q.push_back(0);
        exp_q.push_back(0);
        m_clips   = 0;
        dut_clips = 0;
    endtask

    task automatic model_mix();
        int sum;
        sum = 0;
        for (int v = 0; v < NV; v++) begin
            int inc_v;
            int g;
            inc_v = int'(phase_inc[v*PW +: PW]);
            g     = m_gain[v];
`ifdef SOFT_GATE_EN
            if (key_on[v] || g > 0) begin
                sum += (wave_of(m_phase[v], wave_sel) * g) >>> 4;
                m_phase[v] = (m_phase[v] + inc_v) % 65536;
            end else begin
                m_phase[v] = 0;
            end
            m_gain[v] = key_on[v] ? ((g < 15) ? g + 1 : 15) : ((g > 0) ? g - 1 : 0);
`else
            if (key_on[v]) begin
                sum += wave_of(m_phase[v], wave_sel);
                m_phase[v] = (m_phase[v] + inc_v) % 65536;
            end else begin
                m_phase[v] = 0;
            end
            m_gain[v] = g;
`endif
        end
        if (sum > 32767) begin
            sum = 32767;
            m_clips++;
        end else if (sum < -32767) begin
            sum = -32767;
            m_clips++;
        end
        exp_q.push_back(sum);
    endtask

    // ---------------- output monitor ----------------
    int cyc = 0;
    always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

    logic              bck_q, lr_q;
    logic signed [15:0] word;
    int                nbits, n_stb, n_rise, last_stb, last_rise, last_exp;

    always @(negedge clk) begin
        if (cyc == 0) begin
            bck_q    = 1'b0;
            lr_q     = 1'b0;
            nbits    = 0;
            n_stb    = 0;
            n_rise   = 0;
            last_exp = 0;
            word     = '0;
            model_reset();
        end else begin
            if (sample_stb) begin
                if (n_stb == 0) chk("first_stb_cycle", cyc, 384);
                else            chk("stb_period", cyc - last_stb, 384);
                last_stb = cyc;
                n_stb++;
                model_mix();
            end
            if (clip) dut_clips++;
            if (aud_bck && !bck_q) begin
                if (n_rise == 0)     chk("bck_first_rise", cyc, 6);
                else if (n_rise < 4) chk("bck_period", cyc - last_rise, 12);
                last_rise = cyc;
                n_rise++;
                if (aud_lrck != lr_q) begin
                    nbits = 0;
                    lr_q  = aud_lrck;
                end
                word = {word[14:0], aud_data};
                nbits++;
                if (nbits == DW) begin
                    if (!aud_lrck) begin
                        if (exp_q.size() == 0) begin
                            chk("model_underrun", 0, 1);
                        end else begin
                            last_exp = exp_q.pop_front();
                            chk("left_word", word, last_exp);
                            chk("clip_count", dut_clips, m_clips);
                        end
                    end else begin
                        chk("right_word", word, last_exp);
                    end
                    nbits = 0;
                end
            end
            bck_q = aud_bck;
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_stb();
        int t;
        t = 0;
        while (!sample_stb && t < 1000) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (t >= 1000) chk("stb_timeout", 0, 1);
        else tick(1);
    endtask

    task automatic segment(input logic [NV-1:0] k, input logic [NV*PW-1:0] inc,
                           input logic [1:0] w, input int frames);
        wait_stb();
        tick(40);
        key_on    = k;
        phase_inc = inc;
        wave_sel  = w;
        repeat (frames - 1) wait_stb();
    endtask

    function automatic logic [NV*PW-1:0] all_inc(input int a, input int b, input int c, input int d);
        return {PW'(d), PW'(c), PW'(b), PW'(a)};
    endfunction

    initial begin
        logic [NV*PW-1:0] rinc;
        rst       = 1'b1;
        key_on    = 4'b0001;
        phase_inc = all_inc(16384, 0, 0, 0);
        wave_sel  = 2'b01;
        tick(5);
        chk("rst_bck", aud_bck, 0);
        chk("rst_lrck", aud_lrck, 0);
        chk("rst_data", aud_data, 0);
        chk("rst_stb", sample_stb, 0);
        chk("rst_clip", clip, 0);
        rst = 1'b0;

        repeat (10) wait_stb();                                   // square +,+,-,-
        segment(4'b1111, all_inc(0, 0, 0, 0), 2'b01, 4);          // saturation
        segment(4'b0001, all_inc(4096, 0, 0, 0), 2'b10, 20);      // saw ramp
        segment(4'b0001, all_inc(4096, 0, 0, 0), 2'b01, 10);      // gate on
        segment(4'b0000, all_inc(4096, 0, 0, 0), 2'b01, 3);       // gate off
        segment(4'b0001, all_inc(601, 0, 0, 0), 2'b00, 30);       // sine
        segment(4'b0000, all_inc(601, 0, 0, 0), 2'b00, 4);        // silence
        for (int s = 0; s < 8; s++) begin
            for (int v = 0; v < NV; v++) rinc[v*PW +: PW] = PW'($urandom_range(0, 12000));
            segment(NV'($urandom), rinc, 2'($urandom), 4);
        end

        wait_stb();                                               // reset mid-frame
        tick(150);
        rst = 1'b1;
        tick(3);
        rst = 1'b0;
        for (int v = 0; v < NV; v++) rinc[v*PW +: PW] = PW'($urandom_range(0, 12000));
        key_on    = 4'b0110;
        phase_inc = rinc;
        wave_sel  = 2'b11;
        repeat (4) wait_stb();
        tick(400);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        repeat (200000) @(posedge clk);
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
